// File: rtl/risc_controller_if.sv
// Controller-to-datapath strobe bundle for the 8-bit RISC CPU.
// Strobes are combinational from phase/opcode and valid in the same cycle as phase.
interface risc_controller_if #(
  parameter int OPCODE_WIDTH = 3
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic [2:0]              phase;
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    halt;
  logic                    inc_pc;
  logic                    ld_pc;
  logic                    ld_ac;
  logic                    wr;
  logic                    data_e;

  modport master (
    input  opcode, zero,
    output phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e
  );
endinterface

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer: one pass through phases 0..7 executes one
// instruction; a HLT parks the sequencer at OP_ADDR until reset.
module risc_controller #(
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  risc_controller_if.master   bus
);
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  assign is_hlt   = (bus.opcode == OP_HLT);
  assign is_skz   = (bus.opcode == OP_SKZ);
  assign is_sto   = (bus.opcode == OP_STO);
  assign is_jmp   = (bus.opcode == OP_JMP);
  assign is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                    (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      // HLT freezes the phase at OP_ADDR instead of advancing.
      if (phase_q == OP_ADDR && is_hlt) halted_d = 1'b1;
      else                              phase_d  = phase_e'(phase_q + 3'd1);
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    // Reset overrides the decode directly so a pending write cannot linger.
    if (rst) begin
      bus.sel = 1'b1;
    end else if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = !is_hlt;
          bus.halt   = is_hlt;
        end
        OP_FETCH:   bus.rd = is_aluop;
        ALU_OP: begin
          bus.rd     = is_aluop;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = is_aluop;
          bus.ld_ac  = is_aluop;
          bus.inc_pc = is_jmp;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign bus.phase = phase_q;
endmodule
